// File: rtl/xnor_serial_compare_ctrl_pkg.sv
// Shared definitions for the bit-serial XNOR compare controller:
// FSM state encoding and the match-count width derivation.
package xnor_serial_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..width inclusive (width itself must fit).
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xnor_serial_compare_ctrl_xnor_logic.sv
// Single-bit XNOR logic cell: c = ~(a ^ b). This is the one shared datapath
// element that the compare controller sequences over every operand bit.
module xnor_logic (
  input  logic a,
  input  logic b,
  output logic c
);

  assign c = ~(a ^ b);

endmodule

// File: rtl/xnor_serial_compare_ctrl.sv
// Bit-serial equality / match-count controller. Latches two operands on an
// accepted start, walks them LSB first through one shared XNOR cell, counts
// matching positions and raises a one-cycle done with equal/match_cnt.
// Optional macro XNOR_EARLY_EXIT_EN: stop at the first mismatching bit.
module xnor_serial_compare_ctrl
  import xnor_serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [IDX_W-1:0] bit_idx;
  logic             bit_match;
  logic [CNT_W-1:0] cnt_nxt;

  // Shared cell always looks at the current LSBs of the shift registers.
  xnor_logic u_xnor (
    .a (sh_a[0]),
    .b (sh_b[0]),
    .c (bit_match)
  );

  assign cnt_nxt = bit_match ? match_cnt + CNT_W'(1) : match_cnt;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one SHIFT per bit, a single DONE cycle, then back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_idx == LAST_IDX) state_nxt = DONE;
`ifdef XNOR_EARLY_EXIT_EN
        if (!bit_match) state_nxt = DONE;
`endif
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shifting and counting; results hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      bit_idx   <= '0;
      match_cnt <= '0;
      equal     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh_a      <= op_a;
          sh_b      <= op_b;
          bit_idx   <= '0;
          match_cnt <= '0;
          equal     <= 1'b0;
        end
        SHIFT: begin
          sh_a      <= sh_a >> 1;
          sh_b      <= sh_b >> 1;
          bit_idx   <= bit_idx + IDX_W'(1);
          match_cnt <= cnt_nxt;
          // Resolve equal on the way into DONE so it is valid alongside done.
          if (state_nxt == DONE) equal <= (cnt_nxt == FULL_CNT);
        end
        default: ;
      endcase
    end
  end

endmodule
